// File: rtl/operand_a_if.sv
// Operand-A stage bundle: DOF request side, EX/WB bypass sources, and the registered operand to EX.
// The stage module uses the slave modport and the requester/bench uses master.
interface operand_a_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    A_addr;
    logic [WIDTH-1:0] A_data;
    logic [WIDTH-1:0] PC_1;
    logic             MA;
    logic             ex_wr_en;
    logic [AW-1:0]    ex_wr_addr;
    logic [WIDTH-1:0] ex_result;
    logic             wb_wr_en;
    logic [AW-1:0]    wb_wr_addr;
    logic [WIDTH-1:0] wb_result;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [1:0]       out_src;
    logic [CNT_W-1:0] fwd_count;

    modport slave (
        input  in_valid, A_addr, A_data, PC_1, MA,
        input  ex_wr_en, ex_wr_addr, ex_result,
        input  wb_wr_en, wb_wr_addr, wb_result,
        input  flush, out_ready,
        output in_ready, out_valid, out, out_src, fwd_count
    );

    modport master (
        output in_valid, A_addr, A_data, PC_1, MA,
        output ex_wr_en, ex_wr_addr, ex_result,
        output wb_wr_en, wb_wr_addr, wb_result,
        output flush, out_ready,
        input  in_ready, out_valid, out, out_src, fwd_count
    );
endinterface

// File: rtl/operand_a_stage.sv
// Operand-A select (PC_1 / EX bypass / WB bypass / register) into a one-deep output register.
// EX/WB bypass and the forward-event counter exist only when OPA_FWD_EN is defined.
module operand_a_stage #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    operand_a_if.slave  bus
);
    // state    | meaning
    // ST_EMPTY | no operand held, out_valid=0
    // ST_FULL  | operand presented to EX, out_valid=1
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [1:0]       sel_src;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       src_q;
    logic [CNT_W-1:0] cnt_q;

    assign bus.in_ready = (state_q == ST_EMPTY) | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    // a same-cycle flush drops the request entirely, including its counter event
    assign load         = accept & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if (bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

`ifdef OPA_FWD_EN
    logic ex_hit;
    logic wb_hit;

    // r0 is hard-wired zero, so a write to it must never be bypassed
    assign ex_hit = bus.ex_wr_en && (bus.ex_wr_addr == bus.A_addr) && (bus.A_addr != '0);
    assign wb_hit = bus.wb_wr_en && (bus.wb_wr_addr == bus.A_addr) && (bus.A_addr != '0);

    always_comb begin
        sel_data = bus.A_data;
        sel_src  = 2'd0;
        if (bus.MA) begin
            sel_data = bus.PC_1;
            sel_src  = 2'd1;
        end else if (ex_hit) begin
            sel_data = bus.ex_result;
            sel_src  = 2'd2;
        end else if (wb_hit) begin
            sel_data = bus.wb_result;
            sel_src  = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load && sel_src[1] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{bus.ex_wr_en, bus.ex_wr_addr, bus.ex_result,
                          bus.wb_wr_en, bus.wb_wr_addr, bus.wb_result, bus.A_addr};

    always_comb begin
        sel_data = bus.A_data;
        sel_src  = 2'd0;
        if (bus.MA) begin
            sel_data = bus.PC_1;
            sel_src  = 2'd1;
        end
    end

    assign cnt_q = '0;
`endif

    // operand data is only written on a real load; drain and flush leave it intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            src_q <= 2'd0;
        end else if (load) begin
            out_q <= sel_data;
            src_q <= sel_src;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out       = out_q;
    assign bus.out_src   = src_q;
    assign bus.fwd_count = cnt_q;
endmodule

// File: tb/tb_operand_a_stage.sv
// Directed bench for operand_a_stage with a queue scoreboard; expectations follow OPA_FWD_EN.
module tb_operand_a_stage;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       src;
    } item_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    item_t            sb[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_out;
    logic [1:0]       m_src;
    logic [CNT_W-1:0] m_cnt;

    operand_a_if #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) ifc ();

    operand_a_stage #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic item_t model_sel();
        item_t it;
        it.data = ifc.A_data;
        it.src  = 2'd0;
        if (ifc.MA) begin
            it.data = ifc.PC_1;
            it.src  = 2'd1;
        end
`ifdef OPA_FWD_EN
        else if (ifc.ex_wr_en && ifc.ex_wr_addr == ifc.A_addr && ifc.A_addr != 0) begin
            it.data = ifc.ex_result;
            it.src  = 2'd2;
        end else if (ifc.wb_wr_en && ifc.wb_wr_addr == ifc.A_addr && ifc.A_addr != 0) begin
            it.data = ifc.wb_result;
            it.src  = 2'd3;
        end
`endif
        return it;
    endfunction

    // entered at a falling edge with inputs already driven; returns at the next falling edge
    task automatic tick();
        logic  exp_rdy;
        logic  acc;
        logic  ld;
        item_t it;
        #1;
        exp_rdy = !m_valid || ifc.out_ready;
        check("in_ready", 64'(ifc.in_ready), 64'(exp_rdy));
        acc = ifc.in_valid && exp_rdy;
        ld  = acc && !ifc.flush;
        if (ld) begin
            it = model_sel();
            sb.push_back(it);
            if (it.src[1] && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        if (ifc.flush)          m_valid = 1'b0;
        else if (acc)           m_valid = 1'b1;
        else if (ifc.out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check("out_valid", 64'(ifc.out_valid), 64'(m_valid));
        check("fwd_count", 64'(ifc.fwd_count), 64'(m_cnt));
        if (ld) begin
            it    = sb.pop_front();
            m_out = it.data;
            m_src = it.src;
        end
        check("out", 64'(ifc.out), 64'(m_out));
        check("out_src", 64'(ifc.out_src), 64'(m_src));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifc.in_valid   = 1'b0;
        ifc.A_addr     = '0;
        ifc.A_data     = '0;
        ifc.PC_1       = '0;
        ifc.MA         = 1'b0;
        ifc.ex_wr_en   = 1'b0;
        ifc.ex_wr_addr = '0;
        ifc.ex_result  = '0;
        ifc.wb_wr_en   = 1'b0;
        ifc.wb_wr_addr = '0;
        ifc.wb_result  = '0;
        ifc.flush      = 1'b0;
        ifc.out_ready  = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        #1;
        check({tag, "_valid"}, 64'(ifc.out_valid), 64'(0));
        check({tag, "_out"}, 64'(ifc.out), 64'(0));
        check({tag, "_src"}, 64'(ifc.out_src), 64'(0));
        check({tag, "_cnt"}, 64'(ifc.fwd_count), 64'(0));
        check({tag, "_rdy"}, 64'(ifc.in_ready), 64'(1));
        m_valid = 1'b0;
        m_out   = '0;
        m_src   = 2'd0;
        m_cnt   = '0;
        sb.delete();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        reset_checks("reset");
        ifc.out_ready = 1'b0;
        #1;
        check("reset_rdy_hold", 64'(ifc.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;

        // PC_1 selection
        ifc.in_valid = 1'b1; ifc.MA = 1'b1; ifc.PC_1 = 32'h0000_0104;
        tick();
        check("pc1_out", 64'(ifc.out), 64'h104);
        check("pc1_src", 64'(ifc.out_src), 64'd1);
        idle_inputs();
        tick();

        // EX and WB both match: EX wins
        ifc.in_valid = 1'b1; ifc.A_addr = 5'd3; ifc.A_data = 32'h0000_1234;
        ifc.ex_wr_en = 1'b1; ifc.ex_wr_addr = 5'd3; ifc.ex_result = 32'hAAAA_0000;
        ifc.wb_wr_en = 1'b1; ifc.wb_wr_addr = 5'd3; ifc.wb_result = 32'h0000_5555;
        tick();

        // r0 never forwarded
        ifc.A_addr = 5'd0; ifc.A_data = '0; ifc.ex_wr_addr = 5'd0; ifc.wb_wr_addr = 5'd0;
        tick();
        check("r0_src", 64'(ifc.out_src), 64'd0);

        // WB-only match, then MA overrides a matching EX
        ifc.A_addr = 5'd7; ifc.A_data = 32'h0BAD_0007; ifc.ex_wr_addr = 5'd8; ifc.wb_wr_addr = 5'd7;
        tick();
        ifc.MA = 1'b1; ifc.PC_1 = 32'h0000_0200; ifc.ex_wr_addr = 5'd7;
        tick();
        idle_inputs();
        tick();

        // accept 0x11, hold three cycles with changing bypass data, then drain
        ifc.in_valid = 1'b1; ifc.A_addr = 5'd5; ifc.A_data = 32'h11;
        tick();
        ifc.out_ready = 1'b0; ifc.ex_wr_en = 1'b1; ifc.ex_wr_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            ifc.ex_result = 32'hC0DE_0000 + i;
            ifc.A_data    = 32'h22 + i;
            tick();
            check("hold_out", 64'(ifc.out), 64'h11);
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        tick();
        check("drain_valid", 64'(ifc.out_valid), 64'd0);
        idle_inputs();

        // back-to-back replacement
        ifc.in_valid = 1'b1; ifc.ex_wr_en = 1'b1; ifc.ex_wr_addr = 5'd9;
        for (int i = 0; i < 6; i++) begin
            ifc.A_addr    = AW'(8 + (i % 3));
            ifc.A_data    = 32'h1000 + i;
            ifc.ex_result = 32'hE000 + i;
            ifc.MA        = (i == 4);
            ifc.PC_1      = 32'h3000 + i;
            tick();
        end
        idle_inputs();
        tick();

        // flush with a same-cycle WB-forwarded accept drops it
        ifc.in_valid = 1'b1; ifc.A_addr = 5'd4; ifc.A_data = 32'h44;
        ifc.wb_wr_en = 1'b1; ifc.wb_wr_addr = 5'd4; ifc.wb_result = 32'h0000_F00D;
        ifc.flush = 1'b1;
        tick();
        check("flush_acc_valid", 64'(ifc.out_valid), 64'd0);
        // flush of a held operand
        ifc.flush = 1'b0;
        tick();
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        tick();
        ifc.flush = 1'b1;
        tick();
        idle_inputs();
        tick();

        // reset in the middle of a hold
        ifc.in_valid = 1'b1; ifc.MA = 1'b1; ifc.PC_1 = 32'h0000_0ABC;
        tick();
        ifc.out_ready = 1'b0; ifc.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        reset_checks("midhold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        ifc.in_valid = 1'b1; ifc.A_addr = 5'd2; ifc.A_data = 32'h0000_0202;
        tick();
        idle_inputs();
        tick();

        // counter saturation
        ifc.in_valid = 1'b1; ifc.ex_wr_en = 1'b1; ifc.ex_wr_addr = 5'd6; ifc.A_addr = 5'd6;
        for (int i = 0; i < 20; i++) begin
            ifc.ex_result = 32'h5A00 + i;
            ifc.A_data    = 32'h6600 + i;
            tick();
        end
        idle_inputs();
        tick();
`ifdef OPA_FWD_EN
        check("sat_cnt", 64'(ifc.fwd_count), 64'd15);
`else
        check("nofwd_cnt", 64'(ifc.fwd_count), 64'd0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
